// File: rtl/cnn_pkg.sv
// Shared sizes, FSM encodings and packed bus types for the conv/pool engine.
package cnn_pkg;

    localparam int NUM_KERNELS = 2;
    localparam int TAPS        = 4;
    localparam int PIX_W       = 8;
    localparam int POOL_WIN    = 4;
    localparam int SHIFT       = 2;

    // One extra index bit so an out-of-range slot number is representable and can be flagged.
    localparam int KIDX_W  = $clog2(NUM_KERNELS + 1);
    localparam int CNT_W   = (POOL_WIN > 2) ? $clog2(POOL_WIN) : 1;
    localparam int PROD_W  = 2 * PIX_W + 1;
    localparam int SUM_W   = PROD_W + $clog2(TAPS);
    localparam int SAT_MAX = (1 << PIX_W) - 1;

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t LOAD  = 2'd1;
    localparam state_t RUN   = 2'd2;
    localparam state_t DRAIN = 2'd3;

    typedef logic [TAPS*PIX_W-1:0]        pix_win_t;
    typedef logic [TAPS*PIX_W-1:0]        kern_t;
    typedef logic [NUM_KERNELS*PIX_W-1:0] pool_vec_t;

    function automatic logic [PIX_W-1:0] relu_scale_sat(input logic signed [SUM_W-1:0] acc);
        logic signed [SUM_W-1:0] scaled;
        scaled = acc >>> SHIFT;
        if (acc[SUM_W-1])
            return '0;
        if (scaled > SUM_W'(SAT_MAX))
            return '1;
        return scaled[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/cnn_conv_pool_engine_if.sv
// Control, kernel-write, pixel-in and pooled-out handshake bundle of the conv/pool engine.
interface cnn_conv_pool_engine_if;
    import cnn_pkg::*;

    logic              learn;
    logic              classify;
    logic              kr_wr_en;
    logic [KIDX_W-1:0] kr_wr_idx;
    kern_t             kr_wr_data;
    logic              pix_valid;
    logic              pix_ready;
    pix_win_t          pixels;
    logic              pool_valid;
    logic              pool_ready;
    pool_vec_t         pool_data;
    logic              busy;
    logic              kr_err;

    modport master (
        output learn, classify, kr_wr_en, kr_wr_idx, kr_wr_data, pix_valid, pixels, pool_ready,
        input  pix_ready, pool_valid, pool_data, busy, kr_err
    );

    modport slave (
        input  learn, classify, kr_wr_en, kr_wr_idx, kr_wr_data, pix_valid, pixels, pool_ready,
        output pix_ready, pool_valid, pool_data, busy, kr_err
    );

endinterface

// File: rtl/conv_tap_mac.sv
// Per-kernel conv datapath: registered tap products, then adder tree with ReLU, scale and saturation.
module conv_tap_mac
    import cnn_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  pix_win_t         pixels,
    input  kern_t            weights,
    output logic [PIX_W-1:0] result
);

    logic signed [PROD_W-1:0] prod_c [TAPS];
    logic signed [PROD_W-1:0] prod_q [TAPS];
    logic signed [SUM_W-1:0]  sum_c;

    // Pixels are zero-extended so 255 stays positive against signed weights.
    always_comb begin
        for (int t = 0; t < TAPS; t++) begin
            prod_c[t] = $signed(PROD_W'(pixels[t*PIX_W +: PIX_W])) *
                        PROD_W'($signed(weights[t*PIX_W +: PIX_W]));
        end
    end

    always_comb begin
        sum_c = '0;
        for (int t = 0; t < TAPS; t++) begin
            sum_c = sum_c + SUM_W'(prod_q[t]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < TAPS; t++) begin
                prod_q[t] <= '0;
            end
            result <= '0;
        end else if (en) begin
            for (int t = 0; t < TAPS; t++) begin
                prod_q[t] <= prod_c[t];
            end
            result <= relu_scale_sat(sum_c);
        end
    end

endmodule

// File: rtl/cnn_conv_pool_engine.sv
// Conv/pool front end: kernel bank, mode FSM, parallel conv pipes, running max-pool and output handshake.
module cnn_conv_pool_engine
    import cnn_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    cnn_conv_pool_engine_if.slave bus
);

    state_t           state;
    kern_t            bank [NUM_KERNELS];
    logic             kr_err_q;
    logic             v1;
    logic             v2;
    logic [CNT_W-1:0] count;
    logic [PIX_W-1:0] conv_res [NUM_KERNELS];
    logic [PIX_W-1:0] max_q    [NUM_KERNELS];
    logic [PIX_W-1:0] max_next [NUM_KERNELS];
    logic             pool_valid_q;
    pool_vec_t        pool_data_q;
    logic             pool_last;
    logic             stall;
    logic             accept;
    logic             pipe_empty;

    // Only a result that would overwrite a still-unread pooled vector stalls the pipe.
    assign pool_last  = (count == CNT_W'(POOL_WIN - 1));
    assign stall      = pool_valid_q & ~bus.pool_ready & v2 & pool_last;
    assign accept     = bus.pix_valid & bus.pix_ready;
    assign pipe_empty = ~v1 & ~v2;

    assign bus.pix_ready  = (state == RUN) & ~stall;
    assign bus.pool_valid = pool_valid_q;
    assign bus.pool_data  = pool_data_q;
    assign bus.busy       = (state != IDLE);
    assign bus.kr_err     = kr_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.learn)
                        state <= LOAD;
                    else if (bus.classify)
                        state <= RUN;
                end
                LOAD:  if (!bus.learn) state <= IDLE;
                RUN:   if (!bus.classify) state <= DRAIN;
                DRAIN: if (pipe_empty && !pool_valid_q) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_KERNELS; k++) begin
                bank[k] <= '0;
            end
            kr_err_q <= 1'b0;
        end else if (state == LOAD && bus.kr_wr_en) begin
            if (bus.kr_wr_idx >= KIDX_W'(NUM_KERNELS))
                kr_err_q <= 1'b1;
            for (int k = 0; k < NUM_KERNELS; k++) begin
                if (bus.kr_wr_idx == KIDX_W'(k))
                    bank[k] <= bus.kr_wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else if (!stall) begin
            v1 <= accept;
            v2 <= v1;
        end
    end

    for (genvar k = 0; k < NUM_KERNELS; k++) begin : g_mac
        conv_tap_mac u_mac (
            .clk     (clk),
            .rst     (rst),
            .en      (~stall),
            .pixels  (bus.pixels),
            .weights (bank[k]),
            .result  (conv_res[k])
        );
    end

    // The first result of each pooling window replaces whatever max is left from the last one.
    always_comb begin
        for (int k = 0; k < NUM_KERNELS; k++) begin
            max_next[k] = (count == '0 || conv_res[k] > max_q[k]) ? conv_res[k] : max_q[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= '0;
            pool_valid_q <= 1'b0;
            pool_data_q  <= '0;
            for (int k = 0; k < NUM_KERNELS; k++) begin
                max_q[k] <= '0;
            end
        end else begin
            if (pool_valid_q && bus.pool_ready)
                pool_valid_q <= 1'b0;
            if (v2 && !stall) begin
                if (pool_last) begin
                    count        <= '0;
                    pool_valid_q <= 1'b1;
                    for (int k = 0; k < NUM_KERNELS; k++) begin
                        pool_data_q[k*PIX_W +: PIX_W] <= max_next[k];
                    end
                end else begin
                    count <= count + CNT_W'(1);
                    for (int k = 0; k < NUM_KERNELS; k++) begin
                        max_q[k] <= max_next[k];
                    end
                end
            end else if (state == DRAIN && pipe_empty) begin
                count <= '0;
            end
        end
    end

endmodule
